riscv_fetch_align: RTL and testbench
====================================

Name: riscv_fetch_align

Overview:
- Fetch-stage front end that sits directly upstream of the F/D pipeline register and drives its pc/inst/pcplus4/cinst/cillegal inputs.
- Owns the program counter and the 32-bit instruction-memory read port.
- Aligns mixed 16-bit (RVC) and 32-bit instructions that may straddle word boundaries, using a one-halfword buffer.
- Accepts stall and redirect (branch/jump/trap) control from the hazard/execute logic.

Parameters:
- RESET_VECTOR, 64'h0000_0000_0000_1000, PC value loaded on reset; bit 0 must be 0.

Ports:
- i_riscv_fd_clk  in  1  clock, rising edge.
- i_riscv_fd_rst  in  1  reset, asynchronous, active-high.
- i_riscv_fetch_stall  in  1  hold the PC, buffer and state.
- i_riscv_fetch_redirect  in  1  load a new PC and discard the buffered half.
- i_riscv_fetch_redirect_pc  in  64  redirect target; bit 0 is ignored and treated as 0.
- o_riscv_fetch_imem_addr  out  64  word-aligned read address; bits [1:0] are always 0.
- i_riscv_fetch_imem_rdata  in  32  read data for o_riscv_fetch_imem_addr, returned in the same cycle.
- i_riscv_fetch_imem_valid  in  1  rdata is valid this cycle.
- o_riscv_fd_pc_f  out  64  PC of the presented instruction.
- o_riscv_fd_inst_f  out  32  raw instruction; for RVC this is {16'b0, half}.
- o_riscv_fd_cinst_f  out  16  RVC halfword; 0 when the instruction is 32-bit.
- o_riscv_fd_pcplus4_f  out  64  pc+2 for RVC, pc+4 for 32-bit.
- o_riscv_fd_cillegal_inst_f  out  1  RVC halfword == 16'h0000.
- o_riscv_fetch_valid  out  1  outputs hold a real instruction; 0 means bubble.

Behaviour:
- State registers:
  - pc_q[63:0], reset to RESET_VECTOR.
  - buf_q[15:0], reset to 0.
  - state: EMPTY or HALF, reset to EMPTY.
  - All registers are reset asynchronously on i_riscv_fd_rst.
- HALF means buf_q holds the halfword located at pc_q; pc_q[1] is then always 1.
- "Compressed" means half[1:0] != 2'b11.
- The fetch outputs are combinational from pc_q, buf_q, state and rdata; the F/D register samples them.
- Output values during and just after reset:
  - o_riscv_fetch_valid follows the EMPTY decode below; it is 1 only if i_riscv_fetch_imem_valid is 1.
  - o_riscv_fd_pc_f = RESET_VECTOR.
  - o_riscv_fetch_imem_addr = {RESET_VECTOR[63:2], 2'b00}.
  - When o_riscv_fetch_valid = 0, inst/cinst/cillegal are driven to 0.
- EMPTY state, pc_q[1] = 0, addr = pc_q (word w):
  - w[1:0] != 11: RVC w[15:0]; next pc = pc_q+2; buf_q <= w[31:16]; next state HALF.
  - Otherwise: 32-bit instruction w; next pc = pc_q+4; state stays EMPTY.
- EMPTY state, pc_q[1] = 1 (only reachable after a redirect), addr = pc_q & ~3:
  - w[17:16] != 11: RVC w[31:16]; next pc = pc_q+2; next state EMPTY.
  - Otherwise (straddle): buf_q <= w[31:16]; next state HALF; pc_q unchanged; o_riscv_fetch_valid = 0 (one bubble).
- HALF state, buf_q compressed:
  - Present RVC buf_q; next pc = pc_q+2; next state EMPTY.
  - No memory data is required; valid is independent of i_riscv_fetch_imem_valid.
  - o_riscv_fetch_imem_addr = pc_q+2, word-aligned.
- HALF state, buf_q not compressed:
  - addr = pc_q+2 (word-aligned); inst = {w[15:0], buf_q}.
  - Next pc = pc_q+4; buf_q <= w[31:16]; state stays HALF.
  - No bubble.
- Memory not ready: whenever the current case needs rdata and i_riscv_fetch_imem_valid = 0:
  - o_riscv_fetch_valid = 0.
  - pc_q, buf_q and state are held.
- Update priority, highest first:
  1. Reset.
  2. Redirect: pc_q <= {i_riscv_fetch_redirect_pc[63:1], 1'b0}; state <= EMPTY; buf_q <= 0. This overrides stall and imem_valid.
  3. Stall: hold all registers; outputs stay stable for the same pc_q/rdata.
  4. Memory not ready: hold (as above).
  5. Normal advance.
- Arithmetic: pc additions are 64-bit and wrap modulo 2^64 with no error.
- Reset asserted mid-operation: the buffered half is discarded and fetch restarts at RESET_VECTOR in state EMPTY.

Test Plan:
- Reset, RESET_VECTOR = 0x1000, mem[0x1000] = 0x00A00093, imem_valid = 1 -> imem_addr = 0x1000, pc_f = 0x1000, inst_f = 0x00A00093, pcplus4_f = 0x1004, valid = 1. Next cycle pc_f = 0x1004.
- mem[0x1004] = 0x05134501, mem[0x1008] = 0xFFFF00A0:
  - Cycle 1: cinst_f = 0x4501, inst_f = 0x00004501, pc_f = 0x1004, pcplus4_f = 0x1006.
  - Cycle 2: pc_f = 0x1006, imem_addr = 0x1008, inst_f = 0x00A00513, pcplus4_f = 0x100A.
  - Cycle 3: state HALF, buf = 0xFFFF, pc_f = 0x100A.
- Redirect to 0x2003, mem[0x2000] = 0x0093xxxx, mem[0x2004] = 0x000000A0:
  - Cycle 1: pc_q = 0x2002, imem_addr = 0x2000, valid = 0 (bubble).
  - Cycle 2: imem_addr = 0x2004, inst_f = 0x00A00093, pcplus4_f = 0x2006.
- Stall held 3 cycles mid-stream -> pc_f/inst_f constant. Redirect to 0x3000 asserted together with stall -> next cycle pc_f = 0x3000, buffer cleared.
- imem_valid = 0 for 2 cycles in EMPTY -> valid = 0, pc_f held. In HALF with compressed buf_q (0x4501) and imem_valid = 0 -> valid = 1, pc advances by 2.
- mem word 0x00000000 at aligned pc -> cinst_f = 0x0000, cillegal_inst_f = 1, pcplus4_f = pc+2. pc_q = 0xFFFF_FFFF_FFFF_FFFC with a 32-bit instruction -> next pc_f = 0x0.

Source files
------------

// File: rtl/riscv_fetch_align.sv
// Fetch front end: owns the PC and the imem read port, and aligns mixed RVC/32-bit
// instructions through a one-halfword buffer. Outputs are combinational from state plus rdata.
module riscv_fetch_align #(
   parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_1000
) (
   input  logic        i_riscv_fd_clk,
   input  logic        i_riscv_fd_rst,
   input  logic        i_riscv_fetch_stall,
   input  logic        i_riscv_fetch_redirect,
   input  logic [63:0] i_riscv_fetch_redirect_pc,
   output logic [63:0] o_riscv_fetch_imem_addr,
   input  logic [31:0] i_riscv_fetch_imem_rdata,
   input  logic        i_riscv_fetch_imem_valid,
   output logic [63:0] o_riscv_fd_pc_f,
   output logic [31:0] o_riscv_fd_inst_f,
   output logic [15:0] o_riscv_fd_cinst_f,
   output logic [63:0] o_riscv_fd_pcplus4_f,
   output logic        o_riscv_fd_cillegal_inst_f,
   output logic        o_riscv_fetch_valid
);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_HALF  = 1'b1;

   logic [63:0] r_pc;
   logic [15:0] r_buf;
   logic [0:0]  r_state;

   logic [63:0] w_pc_p2;
   logic [63:0] w_pc_p4;
   logic [63:0] w_addr;
   logic        w_need_mem;
   logic        w_present;
   logic        w_rvc;
   logic [15:0] w_half;
   logic [31:0] w_inst32;
   logic [63:0] w_nxt_pc;
   logic [15:0] w_nxt_buf;
   logic [0:0]  w_nxt_state;
   logic        w_adv;
   logic        w_valid;

   assign w_pc_p2 = r_pc + 64'd2;
   assign w_pc_p4 = r_pc + 64'd4;

   always_comb begin
      w_addr      = {r_pc[63:2], 2'b00};
      w_need_mem  = 1'b1;
      w_present   = 1'b1;
      w_rvc       = 1'b0;
      w_half      = 16'h0000;
      w_inst32    = i_riscv_fetch_imem_rdata;
      w_nxt_pc    = r_pc;
      w_nxt_buf   = r_buf;
      w_nxt_state = r_state;
      if (r_state == S_HALF) begin
         // In HALF the buffered half sits at pc (pc[1]=1), so the next word is one up.
         w_addr = {r_pc[63:2] + 62'd1, 2'b00};
         if (r_buf[1:0] != 2'b11) begin
            w_need_mem  = 1'b0;
            w_rvc       = 1'b1;
            w_half      = r_buf;
            w_nxt_pc    = w_pc_p2;
            w_nxt_state = S_EMPTY;
         end else begin
            w_inst32  = {i_riscv_fetch_imem_rdata[15:0], r_buf};
            w_nxt_pc  = w_pc_p4;
            w_nxt_buf = i_riscv_fetch_imem_rdata[31:16];
         end
      end else if (!r_pc[1]) begin
         if (i_riscv_fetch_imem_rdata[1:0] != 2'b11) begin
            w_rvc       = 1'b1;
            w_half      = i_riscv_fetch_imem_rdata[15:0];
            w_nxt_pc    = w_pc_p2;
            w_nxt_buf   = i_riscv_fetch_imem_rdata[31:16];
            w_nxt_state = S_HALF;
         end else begin
            w_nxt_pc = w_pc_p4;
         end
      end else begin
         if (i_riscv_fetch_imem_rdata[17:16] != 2'b11) begin
            w_rvc    = 1'b1;
            w_half   = i_riscv_fetch_imem_rdata[31:16];
            w_nxt_pc = w_pc_p2;
         end else begin
            // Upper half starts a 32-bit instruction: buffer it and emit one bubble.
            w_present   = 1'b0;
            w_nxt_buf   = i_riscv_fetch_imem_rdata[31:16];
            w_nxt_state = S_HALF;
         end
      end
   end

   assign w_adv   = !w_need_mem || i_riscv_fetch_imem_valid;
   assign w_valid = w_present && w_adv;

   assign o_riscv_fetch_imem_addr    = w_addr;
   assign o_riscv_fd_pc_f            = r_pc;
   assign o_riscv_fetch_valid        = w_valid;
   assign o_riscv_fd_inst_f          = !w_valid ? 32'h0 : (w_rvc ? {16'h0, w_half} : w_inst32);
   assign o_riscv_fd_cinst_f         = (w_valid && w_rvc) ? w_half : 16'h0;
   assign o_riscv_fd_cillegal_inst_f = w_valid && w_rvc && (w_half == 16'h0000);
   assign o_riscv_fd_pcplus4_f       = w_rvc ? w_pc_p2 : w_pc_p4;

   always_ff @(posedge i_riscv_fd_clk or posedge i_riscv_fd_rst) begin
      if (i_riscv_fd_rst) begin
         r_pc    <= RESET_VECTOR;
         r_buf   <= 16'h0000;
         r_state <= S_EMPTY;
      end else if (i_riscv_fetch_redirect) begin
         r_pc    <= i_riscv_fetch_redirect_pc & ~64'd1;
         r_buf   <= 16'h0000;
         r_state <= S_EMPTY;
      end else if (!i_riscv_fetch_stall && w_adv) begin
         r_pc    <= w_nxt_pc;
         r_buf   <= w_nxt_buf;
         r_state <= w_nxt_state;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Directed bench for riscv_fetch_align: inputs change and outputs are sampled on the falling edge.
module tb_riscv_fetch_align;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [63:0] pc_f;
   logic [31:0] inst_f;
   logic [15:0] cinst_f;
   logic [63:0] pcplus4_f;
   logic        cillegal_f;
   logic        valid_f;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [63:0]];
   int          mem_gen = 0;

   riscv_fetch_align #(.RESET_VECTOR(64'h1000)) dut (
      .i_riscv_fd_clk             (clk),
      .i_riscv_fd_rst             (rst),
      .i_riscv_fetch_stall        (stall),
      .i_riscv_fetch_redirect     (redirect),
      .i_riscv_fetch_redirect_pc  (redirect_pc),
      .o_riscv_fetch_imem_addr    (imem_addr),
      .i_riscv_fetch_imem_rdata   (imem_rdata),
      .i_riscv_fetch_imem_valid   (imem_valid),
      .o_riscv_fd_pc_f            (pc_f),
      .o_riscv_fd_inst_f          (inst_f),
      .o_riscv_fd_cinst_f         (cinst_f),
      .o_riscv_fd_pcplus4_f       (pcplus4_f),
      .o_riscv_fd_cillegal_inst_f (cillegal_f),
      .o_riscv_fetch_valid        (valid_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0000_0013;
   endfunction

   always @(imem_addr or mem_gen) imem_rdata = mem_rd(imem_addr);

   task automatic wr(input logic [63:0] a, input logic [31:0] d);
      mem[a] = d;
      mem_gen++;
   endtask

   task automatic do_redirect(input logic [63:0] target);
      redirect = 1'b1;
      redirect_pc = target;
      @(negedge clk);
      redirect = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      wr(64'h1000, 32'h00A00093);
      wr(64'h1004, 32'h05134501);
      wr(64'h1008, 32'hFFFF00A0);
      wr(64'h100C, 32'h00000013);
      repeat (2) @(negedge clk);
      checks++; if (imem_addr !== 64'h1000) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 64'h1000); end
      checks++; if (pc_f !== 64'h1000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_f, 64'h1000); end
      checks++; if (inst_f !== 32'h00A00093) begin errors++; $display("FAIL reset_inst: got %h expected %h", inst_f, 32'h00A00093); end
      checks++; if (pcplus4_f !== 64'h1004) begin errors++; $display("FAIL reset_pcplus4: got %h expected %h", pcplus4_f, 64'h1004); end
      checks++; if (valid_f !== 1'b1 || cinst_f !== 16'h0) begin errors++; $display("FAIL reset_valid_cinst: got %b/%h expected 1/0000", valid_f, cinst_f); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (pc_f !== 64'h1004) begin errors++; $display("FAIL reset_next_pc: got %h expected %h", pc_f, 64'h1004); end
   endtask

   task automatic test_rvc_mix;
      checks++; if (cinst_f !== 16'h4501 || inst_f !== 32'h00004501) begin errors++; $display("FAIL mix1_inst: got %h/%h expected 4501/00004501", cinst_f, inst_f); end
      checks++; if (pcplus4_f !== 64'h1006) begin errors++; $display("FAIL mix1_pcplus4: got %h expected %h", pcplus4_f, 64'h1006); end
      @(negedge clk);
      checks++; if (pc_f !== 64'h1006 || imem_addr !== 64'h1008) begin errors++; $display("FAIL mix2_pc_addr: got %h/%h expected 1006/1008", pc_f, imem_addr); end
      checks++; if (inst_f !== 32'h00A00513 || cinst_f !== 16'h0) begin errors++; $display("FAIL mix2_inst: got %h/%h expected 00a00513/0000", inst_f, cinst_f); end
      checks++; if (pcplus4_f !== 64'h100A || valid_f !== 1'b1) begin errors++; $display("FAIL mix2_pcplus4_valid: got %h/%b expected 100a/1", pcplus4_f, valid_f); end
      @(negedge clk);
      checks++; if (pc_f !== 64'h100A || imem_addr !== 64'h100C) begin errors++; $display("FAIL mix3_pc_addr: got %h/%h expected 100a/100c", pc_f, imem_addr); end
      checks++; if (inst_f !== 32'h0013FFFF) begin errors++; $display("FAIL mix3_buf_inst: got %h expected %h", inst_f, 32'h0013FFFF); end
      @(negedge clk);
      checks++; if (pc_f !== 64'h100E || cinst_f !== 16'h0 || cillegal_f !== 1'b1) begin errors++; $display("FAIL mix4_illegal: got %h/%h/%b expected 100e/0000/1", pc_f, cinst_f, cillegal_f); end
      checks++; if (pcplus4_f !== 64'h1010 || valid_f !== 1'b1) begin errors++; $display("FAIL mix4_pcplus4_valid: got %h/%b expected 1010/1", pcplus4_f, valid_f); end
   endtask

   task automatic test_redirect;
      wr(64'h2000, 32'h00931234);
      wr(64'h2004, 32'h000000A0);
      do_redirect(64'h2003);
      checks++; if (pc_f !== 64'h2002 || imem_addr !== 64'h2000) begin errors++; $display("FAIL redir_pc_addr: got %h/%h expected 2002/2000", pc_f, imem_addr); end
      checks++; if (valid_f !== 1'b0 || inst_f !== 32'h0) begin errors++; $display("FAIL redir_bubble: got %b/%h expected 0/00000000", valid_f, inst_f); end
      @(negedge clk);
      checks++; if (imem_addr !== 64'h2004 || inst_f !== 32'h00A00093) begin errors++; $display("FAIL redir_straddle: got %h/%h expected 2004/00a00093", imem_addr, inst_f); end
      checks++; if (pc_f !== 64'h2002 || pcplus4_f !== 64'h2006 || valid_f !== 1'b1) begin errors++; $display("FAIL redir_pc: got %h/%h/%b expected 2002/2006/1", pc_f, pcplus4_f, valid_f); end
   endtask

   task automatic test_stall;
      wr(64'h4000, 32'h05134501);
      wr(64'h4004, 32'h000000A0);
      wr(64'h3000, 32'h00A00093);
      wr(64'h3004, 32'h45010001);
      do_redirect(64'h4000);
      checks++; if (pc_f !== 64'h4000 || cinst_f !== 16'h4501) begin errors++; $display("FAIL stall_pre: got %h/%h expected 4000/4501", pc_f, cinst_f); end
      @(negedge clk);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (pc_f !== 64'h4002 || inst_f !== 32'h00A00513) begin errors++; $display("FAIL stall_hold%0d: got %h/%h expected 4002/00a00513", i, pc_f, inst_f); end
      end
      redirect = 1'b1;
      redirect_pc = 64'h3000;
      @(negedge clk);
      stall = 1'b0;
      redirect = 1'b0;
      #1;
      checks++; if (pc_f !== 64'h3000 || imem_addr !== 64'h3000) begin errors++; $display("FAIL stall_redir: got %h/%h expected 3000/3000", pc_f, imem_addr); end
      checks++; if (inst_f !== 32'h00A00093 || valid_f !== 1'b1) begin errors++; $display("FAIL stall_redir_inst: got %h/%b expected 00a00093/1", inst_f, valid_f); end
   endtask

   task automatic test_mem_not_ready;
      imem_valid = 1'b0;
      #1;
      checks++; if (valid_f !== 1'b0 || inst_f !== 32'h0) begin errors++; $display("FAIL nrdy_bubble: got %b/%h expected 0/00000000", valid_f, inst_f); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (pc_f !== 64'h3000 || valid_f !== 1'b0) begin errors++; $display("FAIL nrdy_hold%0d: got %h/%b expected 3000/0", i, pc_f, valid_f); end
      end
      imem_valid = 1'b1;
      @(negedge clk);
      checks++; if (pc_f !== 64'h3004 || cinst_f !== 16'h0001) begin errors++; $display("FAIL nrdy_resume: got %h/%h expected 3004/0001", pc_f, cinst_f); end
      @(negedge clk);
      imem_valid = 1'b0;
      #1;
      checks++; if (pc_f !== 64'h3006 || valid_f !== 1'b1 || cinst_f !== 16'h4501) begin errors++; $display("FAIL nrdy_halfc: got %h/%b/%h expected 3006/1/4501", pc_f, valid_f, cinst_f); end
      checks++; if (imem_addr !== 64'h3008 || pcplus4_f !== 64'h3008) begin errors++; $display("FAIL nrdy_halfc_addr: got %h/%h expected 3008/3008", imem_addr, pcplus4_f); end
      @(negedge clk);
      checks++; if (pc_f !== 64'h3008 || valid_f !== 1'b0) begin errors++; $display("FAIL nrdy_after_half: got %h/%b expected 3008/0", pc_f, valid_f); end
      imem_valid = 1'b1;
   endtask

   task automatic test_zero_and_wrap;
      wr(64'h5000, 32'h00000000);
      wr(64'hFFFF_FFFF_FFFF_FFFC, 32'h00A00093);
      do_redirect(64'h5000);
      checks++; if (cinst_f !== 16'h0 || cillegal_f !== 1'b1 || valid_f !== 1'b1) begin errors++; $display("FAIL zero_illegal: got %h/%b/%b expected 0000/1/1", cinst_f, cillegal_f, valid_f); end
      checks++; if (pcplus4_f !== 64'h5002 || inst_f !== 32'h0) begin errors++; $display("FAIL zero_pcplus4: got %h/%h expected 5002/00000000", pcplus4_f, inst_f); end
      do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
      checks++; if (inst_f !== 32'h00A00093 || pcplus4_f !== 64'h0) begin errors++; $display("FAIL wrap_pcplus4: got %h/%h expected 00a00093/0", inst_f, pcplus4_f); end
      @(negedge clk);
      checks++; if (pc_f !== 64'h0 || inst_f !== 32'h00000013) begin errors++; $display("FAIL wrap_pc: got %h/%h expected 0/00000013", pc_f, inst_f); end
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 64'h0;
      imem_valid = 1'b1;
      test_reset;
      test_rvc_mix;
      test_redirect;
      test_stall;
      test_mem_not_ready;
      test_zero_and_wrap;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
